// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor:
// default geometry, mode encoding and result flag positions.
package cla_pipe_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_BLK   = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned FLAG_CO   = 0;
    localparam int unsigned FLAG_OVF  = 1;
    localparam int unsigned FLAG_ZERO = 2;
    localparam int unsigned NUM_FLAGS = 3;

    // Two's-complement overflow from the sign bits of both effective operands and the result.
    function automatic logic ovf_rule(input logic a_msb, input logic bo_msb, input logic s_msb);
        return (a_msb == bo_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_block.sv
// Combinational BLK-bit carry-lookahead slice: every internal carry is a flat
// sum of generate/propagate products rather than a ripple.
module cla_block #(
    parameter int unsigned BLK = 4
) (
    input  logic [BLK-1:0] a_i,
    input  logic [BLK-1:0] b_i,
    input  logic           ci_i,
    output logic [BLK-1:0] s_o,
    output logic           co_o
);

    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK:0]   c;
    logic           term;

    always_comb begin
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        c    = '0;
        term = 1'b0;
        c[0] = ci_i;
        for (int i = 0; i < int'(BLK); i++) begin
            term = ci_i;
            for (int k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        s_o  = p ^ c[BLK-1:0];
        co_o = c[BLK];
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor with STAGES registered carry
// boundaries, valid/ready handshake on both sides and signed-overflow/zero flags.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned BLK    = DEF_BLK,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSLICE = WIDTH / BLK;
    localparam int unsigned SPS    = NSLICE / STAGES;
    localparam int unsigned SBITS  = SPS * BLK;
    localparam int unsigned LAST   = STAGES - 1;

    if (STAGES < 1 || WIDTH % BLK != 0 || NSLICE % STAGES != 0) begin : g_bad_cfg
        $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of BLK and slices of STAGES");
    end

    function automatic logic [WIDTH-1:0] bit_range(input int unsigned lo, input int unsigned hi);
        logic [WIDTH-1:0] m;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

    logic [WIDTH-1:0]  bo;
    logic              cin;
    logic [WIDTH-1:0]  st_a   [STAGES];
    logic [WIDTH-1:0]  st_bo  [STAGES];
    logic [WIDTH-1:0]  st_sin [STAGES];
    logic [WIDTH-1:0]  st_sum [STAGES];
    logic [STAGES-1:0] st_cin;
    logic [STAGES-1:0] v_q, v_d, adv, ld;
    logic [WIDTH-1:0]  slice_s;
    logic [NSLICE-1:0] slice_ci, slice_co;
    logic              ready_chain;

    assign bo        = (sub == MODE_SUB) ? ~b : b;
    assign cin       = (sub == MODE_SUB) ? 1'b1 : ci;
    assign st_a[0]   = a;
    assign st_bo[0]  = bo;
    assign st_sin[0] = '0;
    assign st_cin[0] = cin;

    for (genvar j = 0; j < NSLICE; j++) begin : g_slice
        localparam int unsigned K = j / SPS;
        if (j % SPS == 0) begin : g_head
            assign slice_ci[j] = st_cin[K];
        end else begin : g_chain
            assign slice_ci[j] = slice_co[j-1];
        end
        cla_block #(
            .BLK(BLK)
        ) u_blk (
            .a_i  (st_a[K][j*BLK +: BLK]),
            .b_i  (st_bo[K][j*BLK +: BLK]),
            .ci_i (slice_ci[j]),
            .s_o  (slice_s[j*BLK +: BLK]),
            .co_o (slice_co[j])
        );
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] OwnMask = bit_range(k * SBITS, (k + 1) * SBITS - 1);
        logic [WIDTH-1:0] sum_q;

        assign st_sum[k] = st_sin[k] | (slice_s & OwnMask);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sum_q <= '0;
            end else if (ld[k]) begin
                sum_q <= st_sum[k];
            end
        end

        if (k < LAST) begin : g_mid
            // Only the operand bits later stages still have to add are carried forward.
            localparam logic [WIDTH-1:0] UpMask = bit_range((k + 1) * SBITS, WIDTH - 1);
            logic [WIDTH-1:0] a_q, bo_q;
            logic             c_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q  <= '0;
                    bo_q <= '0;
                    c_q  <= 1'b0;
                end else if (ld[k]) begin
                    a_q  <= st_a[k] & UpMask;
                    bo_q <= st_bo[k] & UpMask;
                    c_q  <= slice_co[(k+1)*SPS-1];
                end
            end

            assign st_a[k+1]   = a_q;
            assign st_bo[k+1]  = bo_q;
            assign st_sin[k+1] = sum_q;
            assign st_cin[k+1] = c_q;
        end else begin : g_last
            logic [NUM_FLAGS-1:0] flags_d, flags_q;

            always_comb begin
                flags_d            = '0;
                flags_d[FLAG_CO]   = slice_co[NSLICE-1];
                flags_d[FLAG_OVF]  = ovf_rule(st_a[k][WIDTH-1], st_bo[k][WIDTH-1],
                                              st_sum[k][WIDTH-1]);
                flags_d[FLAG_ZERO] = ~|st_sum[k];
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    flags_q <= '0;
                end else if (ld[k]) begin
                    flags_q <= flags_d;
                end
            end

            assign s    = sum_q;
            assign co   = flags_q[FLAG_CO];
            assign ovf  = flags_q[FLAG_OVF];
            assign zero = flags_q[FLAG_ZERO];
        end
    end

    // Ready ripples back from the output: a stage may move if the next one is empty or moving.
    always_comb begin
        adv         = '0;
        ld          = '0;
        v_d         = '0;
        ready_chain = out_ready;
        for (int k = int'(LAST); k >= 0; k--) begin
            adv[k]      = v_q[k] & ready_chain;
            ready_chain = ~v_q[k] | adv[k];
        end
        in_ready = ready_chain;
        ld[0]    = in_valid & ready_chain;
        for (int k = 1; k < int'(STAGES); k++) begin
            ld[k] = adv[k-1];
        end
        v_d = ld | (v_q & ~adv);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    assign out_valid = v_q[LAST];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: three configurations checked against an arithmetic
// reference queue, plus directed vectors with hand-computed results.
module tb_cla_pipe_adder;

    typedef struct packed {
        logic [63:0] s;
        logic        co;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv = '0, irdy, ordy = '1, ov, cin = '0, subm = '0, cow, ovw, zw;
    logic [63:0] ain [3];
    logic [63:0] bin [3];
    logic [63:0] sw  [3];
    logic [31:0] s32;
    logic [15:0] s16;
    logic [63:0] s64;
    int          wd  [3] = '{32, 16, 64};
    res_t        expq [3][$];
    logic [63:0] got [$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          bp_i, bp_got;
    logic        saw_stall, seen;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(32), .BLK(4), .STAGES(2)) u_dut32 (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(ain[0][31:0]), .b(bin[0][31:0]), .ci(cin[0]), .sub(subm[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .s(s32), .co(cow[0]), .ovf(ovw[0]), .zero(zw[0])
    );
    cla_pipe_adder #(.WIDTH(16), .BLK(4), .STAGES(4)) u_dut16 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(ain[1][15:0]), .b(bin[1][15:0]), .ci(cin[1]), .sub(subm[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .s(s16), .co(cow[1]), .ovf(ovw[1]), .zero(zw[1])
    );
    cla_pipe_adder #(.WIDTH(64), .BLK(8), .STAGES(2)) u_dut64 (
        .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(ain[2]), .b(bin[2]), .ci(cin[2]), .sub(subm[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .s(s64), .co(cow[2]), .ovf(ovw[2]), .zero(zw[2])
    );

    assign sw[0] = {32'd0, s32};
    assign sw[1] = {48'd0, s16};
    assign sw[2] = s64;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // Reference: plain (w+1)-bit arithmetic on the effective operands.
    function automatic res_t model(input int w, input logic [63:0] ta, input logic [63:0] tb_v,
                                   input logic tci, input logic tsub);
        res_t        r;
        logic [63:0] mask, am, bo;
        logic [64:0] full;
        mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = ta & mask;
        bo     = (tsub ? ~tb_v : tb_v) & mask;
        full   = {1'b0, am} + {1'b0, bo} + {64'd0, (tsub ? 1'b1 : tci)};
        r.s    = full[63:0] & mask;
        r.co   = full[w];
        r.ovf  = (am[w-1] == bo[w-1]) && (r.s[w-1] != am[w-1]);
        r.zero = (r.s == 64'd0);
        return r;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                expq[d].delete();
            end else begin
                if (expq[d].size() == 0) begin
                    check($sformatf("no_spurious_out[%0d]", d), {63'd0, ov[d]}, 64'd0);
                end else if (ov[d]) begin
                    check($sformatf("s[%0d]", d), sw[d], expq[d][0].s);
                    check($sformatf("co[%0d]", d), {63'd0, cow[d]}, {63'd0, expq[d][0].co});
                    check($sformatf("ovf[%0d]", d), {63'd0, ovw[d]}, {63'd0, expq[d][0].ovf});
                    check($sformatf("zero[%0d]", d), {63'd0, zw[d]}, {63'd0, expq[d][0].zero});
                end
                if (ov[d] && ordy[d] && expq[d].size() > 0) begin
                    void'(expq[d].pop_front());
                end
                if (iv[d] && irdy[d]) begin
                    expq[d].push_back(model(wd[d], ain[d], bin[d], cin[d], subm[d]));
                end
            end
        end
    end

    task automatic directed(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tci, input logic tsub, input logic [31:0] es,
                            input logic eco, input logic eovf, input logic ez);
        @(posedge clk); #1;
        ain[0]  = {32'd0, ta};
        bin[0]  = {32'd0, tb_v};
        cin[0]  = tci;
        subm[0] = tsub;
        ordy[0] = 1'b1;
        iv[0]   = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(negedge clk);
        check({nm, "_not_yet_valid"}, {63'd0, ov[0]}, 64'd0);
        @(negedge clk);
        check({nm, "_valid"}, {63'd0, ov[0]}, 64'd1);
        check({nm, "_s"}, {32'd0, s32}, {32'd0, es});
        check({nm, "_co"}, {63'd0, cow[0]}, {63'd0, eco});
        check({nm, "_ovf"}, {63'd0, ovw[0]}, {63'd0, eovf});
        check({nm, "_zero"}, {63'd0, zw[0]}, {63'd0, ez});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            ain[d] = '0;
            bin[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {63'd0, ov[0]}, 64'd0);
        check("rst_in_ready", {63'd0, irdy[0]}, 64'd1);
        check("rst_s", {32'd0, s32}, 64'd0);
        check("rst_co", {63'd0, cow[0]}, 64'd0);
        check("rst_ovf", {63'd0, ovw[0]}, 64'd0);
        check("rst_zero", {63'd0, zw[0]}, 64'd0);
        rst = 1'b0;

        directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1, 0, 1);
        directed("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 0, 1, 0);
        directed("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1, 1, 0);
        directed("sub_ci_ign", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 0, 0, 0);
        directed("add_ci_chain", 32'h0FFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h1000_0001, 0, 0, 0);
        directed("sub_equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0000_0000, 1, 0, 1);

        // Backpressure: 8 beats a=b=i, downstream stalls for cycles 3..6.
        bp_i = 0;
        bp_got = 0;
        saw_stall = 1'b0;
        got.delete();
        subm[0] = 1'b0;
        cin[0] = 1'b0;
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 60 && bp_got < 8; cyc++) begin
            ain[0]  = 64'(bp_i);
            bin[0]  = 64'(bp_i);
            iv[0]   = (bp_i < 8);
            ordy[0] = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            if (!irdy[0]) begin
                saw_stall = 1'b1;
                check("stall_only_when_blocked", {62'd0, ov[0], ordy[0]}, 64'b10);
            end
            if (iv[0] && irdy[0]) bp_i++;
            if (ov[0] && ordy[0]) begin
                got.push_back(sw[0]);
                bp_got++;
            end
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        check("bp_sent", 64'(bp_i), 64'd8);
        check("bp_saw_stall", {63'd0, saw_stall}, 64'd1);
        check("bp_count", 64'(got.size()), 64'd8);
        for (int k = 0; k < got.size(); k++) begin
            check($sformatf("bp_order[%0d]", k), got[k], 64'(2 * k));
        end

        // Reset with two beats in flight.
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        ain[0] = 64'd100;
        bin[0] = 64'd1;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        ain[0] = 64'd200;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        check("rst_pre_valid", {63'd0, ov[0]}, 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", {63'd0, ov[0]}, 64'd0);
        check("rst_mid_in_ready", {63'd0, irdy[0]}, 64'd1);
        check("rst_mid_s", {32'd0, s32}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ordy[0] = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ov[0]) seen = 1'b1;
        end
        check("rst_no_stale", {63'd0, seen}, 64'd0);

        // Random sweep on all three geometries with random valid/ready.
        @(posedge clk); #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int d = 0; d < 3; d++) begin
                case ($urandom_range(0, 5))
                    0:       ain[d] = '1;
                    1:       ain[d] = '1 >> (65 - wd[d]);
                    default: ain[d] = {$urandom, $urandom};
                endcase
                case ($urandom_range(0, 4))
                    0:       bin[d] = 64'd1;
                    1:       bin[d] = ain[d];
                    default: bin[d] = {$urandom, $urandom};
                endcase
                cin[d]  = 1'($urandom_range(0, 1));
                subm[d] = 1'($urandom_range(0, 1));
                iv[d]   = ($urandom_range(0, 3) != 0);
                ordy[d] = ($urandom_range(0, 2) != 0);
            end
            @(posedge clk); #1;
        end
        iv = '0;
        ordy = '1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("drain_empty[%0d]", d), 64'(expq[d].size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
